// File: rtl/dnn_result_requant.sv
// rtl/dnn_result_requant.sv - requantises accelerator dot-product bursts into a 16-bit output FIFO
//
// Purpose:
//   Requests one burst of BURST_LEN 32-bit dot products from the accelerator.
//   Each result goes through activation, a rounding right shift and 16-bit
//   saturation, then into a first-word fall-through FIFO that a valid/ready
//   consumer drains.
//   A burst is requested only when the FIFO has room for the whole burst.
//
// Configuration macro:
//   ACT_RELU_EN - when defined, ReLU is applied before the shift (outputs 0..32767).
//                 When undefined, there is no activation and negative results are
//                 shifted arithmetically.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request one burst (sampled in IDLE only)
//   shift_amt    in   [4:0] right-shift amount, latched on accepted start
//   rd_req       out  one-cycle read request to the accelerator (EN_readMem)
//   in_valid     in   accelerator result valid (VALID_memVal)
//   in_data      in   [31:0] accelerator result, two's complement
//   out_valid    out  FIFO non-empty
//   out_ready    in   consumer takes the head entry when out_valid is high
//   out_data     out  [15:0] FIFO head, signed
//   busy         out  controller not in IDLE
//   done         out  one-cycle pulse once the last burst result is in the FIFO
//   overflow_err out  sticky flag for a dropped beat, cleared by an accepted start

module dnn_result_requant #(
   parameter int BURST_LEN  = 64,
   parameter int FIFO_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [4:0]  shift_amt,
   output logic        rd_req,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        busy,
   output logic        done,
   output logic        overflow_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] BURST_CNT  = CW'(BURST_LEN);
   localparam logic [AW:0]   BURST_FREE = (AW+1)'(BURST_LEN);
   localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SPACE,
      S_REQ,
      S_RECV,
      S_DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [4:0]          r_shift;
   logic [CW-1:0]       r_beat_cnt;
   logic                r_s1_valid;
   logic signed [32:0]  r_s1_y;
   logic                r_ovf;

   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_count;
   logic [15:0]         r_mem [FIFO_DEPTH];

   logic                w_start_ok;
   logic                w_beat_ok;
   logic [AW:0]         w_free;
   logic signed [32:0]  w_x;
   logic signed [32:0]  w_round;
   logic signed [32:0]  w_sum;
   logic signed [32:0]  w_y;
   logic [15:0]         w_sat;
   logic                w_full;
   logic                w_pop;
   logic                w_push_ok;
   logic                w_drop;

   assign w_start_ok = start && (r_state == S_IDLE);
   // Beats past the end of the burst are treated as if they arrived outside RECV.
   assign w_beat_ok  = in_valid && (r_state == S_RECV) && (r_beat_cnt < BURST_CNT);
   assign w_free     = DEPTH_CNT - r_count;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (start) w_next = S_WAIT_SPACE;
         S_WAIT_SPACE: if (w_free >= BURST_FREE) w_next = S_REQ;
         S_REQ:        w_next = S_RECV;
         S_RECV:       if (w_beat_ok && (r_beat_cnt == BURST_CNT - 1'b1)) w_next = S_DRAIN;
         S_DRAIN:      if (!r_s1_valid) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      rd_req = 1'b0;
      busy   = 1'b1;
      done   = 1'b0;
      case (r_state)
         S_IDLE:  busy   = 1'b0;
         S_REQ:   rd_req = 1'b1;
         // The only stage before the FIFO is S1, so an empty S1 means the
         // last result has already been written.
         S_DRAIN: done   = !r_s1_valid;
         default: ;
      endcase
   end

   // ---------------- Control registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift    <= 5'd0;
         r_beat_cnt <= '0;
      end else begin
         if (w_start_ok) begin
            r_shift    <= shift_amt;
            r_beat_cnt <= '0;
         end else if (w_beat_ok) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

   // ---------------- S1: activation and rounding shift ----------------
   always_comb begin
      w_x = {in_data[31], in_data};
`ifdef ACT_RELU_EN
      if (w_x < 0) w_x = '0;
`endif
      // Adding half an LSB of the result before the arithmetic shift rounds
      // half up. 33 bits hold 2^31-1 + 2^30 without wrapping.
      w_round = (r_shift == 5'd0) ? 33'sd0 : (33'sd1 <<< (r_shift - 5'd1));
      w_sum   = w_x + w_round;
      w_y     = w_sum >>> r_shift;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_y     <= '0;
      end else begin
         r_s1_valid <= w_beat_ok;
         if (w_beat_ok) r_s1_y <= w_y;
      end
   end

   // ---------------- S2: saturation, written straight into the FIFO ----------------
   always_comb begin
      if (r_s1_y > 33'sd32767)       w_sat = 16'h7FFF;
      else if (r_s1_y < -33'sd32768) w_sat = 16'h8000;
      else                           w_sat = r_s1_y[15:0];
   end

   // ---------------- Output FIFO ----------------
   assign w_full    = (r_count == DEPTH_CNT);
   assign w_pop     = out_valid && out_ready;
   assign w_push_ok = r_s1_valid && (!w_full || w_pop);
   assign w_drop    = (in_valid && !w_beat_ok) || (r_s1_valid && !w_push_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset. Resetting the pointers discards the contents.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= w_sat;
   end

   assign out_valid = (r_count != '0);
   assign out_data  = out_valid ? r_mem[r_rd_ptr] : 16'h0000;

   // ---------------- Sticky overflow flag ----------------
   // A drop in the same cycle as an accepted start is still reported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (w_start_ok) begin
         r_ovf <= 1'b0;
      end
   end

   assign overflow_err = r_ovf;

endmodule
